// File: rtl/me_best_match_selector_if.sv
// +--------------------------------------------------------------------------+
// | me_best_match_selector_if : SAD collection / best-MV result bus          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface me_best_match_selector_if #(
  parameter int PE_COUNT  = 16,
  parameter int SAD_WIDTH = 16,
  parameter int MV_WIDTH  = 4
);
  logic                          in_start;
  logic [PE_COUNT-1:0]           in_sad_valid;
  logic [PE_COUNT*SAD_WIDTH-1:0] in_sad_data;
  logic                          in_ack;
  logic                          out_busy;
  logic                          out_valid;
  logic [MV_WIDTH-1:0]           out_mv_x;
  logic [MV_WIDTH-1:0]           out_mv_y;
  logic [SAD_WIDTH-1:0]          out_min_sad;
  logic                          out_seq_err;

  modport master (
    output in_start, in_sad_valid, in_sad_data, in_ack,
    input  out_busy, out_valid, out_mv_x, out_mv_y, out_min_sad, out_seq_err
  );

  modport slave (
    input  in_start, in_sad_valid, in_sad_data, in_ack,
    output out_busy, out_valid, out_mv_x, out_mv_y, out_min_sad, out_seq_err
  );
endinterface

`default_nettype wire

// File: rtl/me_best_match_selector.sv
// +--------------------------------------------------------------------------+
// | me_best_match_selector : minimum-SAD search over 256 candidates, MV out  |
// | Optional macro ME_SIGNED_MV_EN: MV centred on co-located block (-8..+7)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module me_best_match_selector #(
  parameter int PE_COUNT  = 16,
  parameter int SAD_WIDTH = 16,
  parameter int ROW_COUNT = 16,
  parameter int MV_WIDTH  = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  me_best_match_selector_if.slave bus
);

  localparam int CNT_WIDTH = $clog2(PE_COUNT * ROW_COUNT);
  localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [SAD_WIDTH-1:0]  r_best_sad;
  logic [MV_WIDTH-1:0]   r_best_x;
  logic [MV_WIDTH-1:0]   r_best_y;
  logic                  r_seq_err;
  logic                  r_valid;
  logic [MV_WIDTH-1:0]   r_out_x;
  logic [MV_WIDTH-1:0]   r_out_y;
  logic [SAD_WIDTH-1:0]  r_out_sad;

  logic [MV_WIDTH-1:0]   w_pe_idx;
  logic [SAD_WIDTH-1:0]  w_sad;
  logic                  w_any;
  logic                  w_multi;
  logic                  w_accept;
  logic                  w_seq_bad;
  logic [MV_WIDTH-1:0]   w_cand_y;
  logic [MV_WIDTH-1:0]   w_mv_x;
  logic [MV_WIDTH-1:0]   w_mv_y;

  // Lowest set strobe wins; scanning downward leaves the lowest index last.
  always_comb begin
    w_pe_idx = '0;
    w_sad    = '0;
    for (int i = PE_COUNT - 1; i >= 0; i--) begin
      if (bus.in_sad_valid[i]) begin
        w_pe_idx = MV_WIDTH'(i);
        w_sad    = bus.in_sad_data[i*SAD_WIDTH +: SAD_WIDTH];
      end
    end
  end

  assign w_any     = |bus.in_sad_valid;
  assign w_multi   = |(bus.in_sad_valid & (bus.in_sad_valid - PE_COUNT'(1)));
  assign w_accept  = (r_state == ST_COLLECT) && w_any && !bus.in_start;
  assign w_seq_bad = w_multi || (w_pe_idx != r_cnt[MV_WIDTH-1:0]);
  assign w_cand_y  = MV_WIDTH'(r_cnt >> MV_WIDTH);

`ifdef ME_SIGNED_MV_EN
  assign w_mv_x = r_best_x - MV_WIDTH'(PE_COUNT / 2);
  assign w_mv_y = r_best_y - MV_WIDTH'(ROW_COUNT / 2);
`else
  assign w_mv_x = r_best_x;
  assign w_mv_y = r_best_y;
`endif

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // in_start wins in every state; in DONE it doubles as an implicit ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_start) w_state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (bus.in_start)                          w_state_nxt = ST_COLLECT;
        else if (w_accept && (r_cnt == C_CNT_LAST)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.in_start)                 w_state_nxt = ST_COLLECT;
        else if (bus.in_ack && r_valid)   w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_cnt      <= '0;
      r_best_sad <= '1;
      r_best_x   <= '0;
      r_best_y   <= '0;
      r_seq_err  <= 1'b0;
    end else if (bus.in_start) begin
      r_cnt      <= '0;
      r_best_sad <= '1;
      r_best_x   <= '0;
      r_best_y   <= '0;
      r_seq_err  <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_seq_bad) r_seq_err <= 1'b1;
      // Strict compare keeps the earliest candidate on ties.
      if (w_sad < r_best_sad) begin
        r_best_sad <= w_sad;
        r_best_x   <= w_pe_idx;
        r_best_y   <= w_cand_y;
      end
    end
  end

  // Result registers load on the first DONE cycle, then hold until the next DONE.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_valid   <= 1'b0;
      r_out_x   <= '0;
      r_out_y   <= '0;
      r_out_sad <= '0;
    end else begin
      r_valid <= (r_state == ST_DONE) && (w_state_nxt == ST_DONE);
      if ((r_state == ST_DONE) && !r_valid) begin
        r_out_x   <= w_mv_x;
        r_out_y   <= w_mv_y;
        r_out_sad <= r_best_sad;
      end
    end
  end

  assign bus.out_busy    = (r_state == ST_COLLECT);
  assign bus.out_valid   = r_valid;
  assign bus.out_mv_x    = r_out_x;
  assign bus.out_mv_y    = r_out_y;
  assign bus.out_min_sad = r_out_sad;
  assign bus.out_seq_err = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_me_best_match_selector.sv
// +--------------------------------------------------------------------------+
// | tb_me_best_match_selector : directed bench for me_best_match_selector    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_me_best_match_selector;

  localparam int PE_COUNT  = 16;
  localparam int SAD_WIDTH = 16;
  localparam int ROW_COUNT = 16;
  localparam int MV_WIDTH  = 4;

  logic in_clk;
  logic in_rst;
  int   n_total;
  int   n_pass;
  int unsigned sads [256];

  me_best_match_selector_if #(
    .PE_COUNT (PE_COUNT),
    .SAD_WIDTH(SAD_WIDTH),
    .MV_WIDTH (MV_WIDTH)
  ) bus ();

  me_best_match_selector #(
    .PE_COUNT (PE_COUNT),
    .SAD_WIDTH(SAD_WIDTH),
    .ROW_COUNT(ROW_COUNT),
    .MV_WIDTH (MV_WIDTH)
  ) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .bus   (bus)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [3:0] ex_x(input int raw);
`ifdef ME_SIGNED_MV_EN
    return 4'(raw - 8);
`else
    return 4'(raw);
`endif
  endfunction

  function automatic logic [3:0] ex_y(input int raw);
`ifdef ME_SIGNED_MV_EN
    return 4'(raw - 8);
`else
    return 4'(raw);
`endif
  endfunction

  task automatic fill(input int unsigned v);
    for (int i = 0; i < 256; i++) sads[i] = v;
  endtask

  task automatic do_start();
    bus.in_start = 1'b1;
    @(negedge in_clk);
    bus.in_start = 1'b0;
  endtask

  task automatic send_mask(input logic [15:0] mask, input int x, input int unsigned sad);
    logic [PE_COUNT*SAD_WIDTH-1:0] d;
    d = '1;
    d[x*SAD_WIDTH +: SAD_WIDTH] = SAD_WIDTH'(sad);
    bus.in_sad_valid = mask;
    bus.in_sad_data  = d;
    @(negedge in_clk);
    bus.in_sad_valid = '0;
    bus.in_sad_data  = '0;
  endtask

  task automatic send_one(input int x, input int unsigned sad);
    send_mask(16'(1 << x), x, sad);
  endtask

  task automatic run_search(input bit gaps);
    for (int i = 0; i < 256; i++) begin
      send_one(i % 16, sads[i]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge in_clk);
    end
  endtask

  task automatic pulse_ack();
    bus.in_ack = 1'b1;
    @(negedge in_clk);
    bus.in_ack = 1'b0;
    @(negedge in_clk);
  endtask

  initial begin
    logic [PE_COUNT*SAD_WIDTH-1:0] d;
    n_total = 0;
    n_pass  = 0;
    in_rst           = 1'b1;
    bus.in_start     = 1'b0;
    bus.in_sad_valid = '0;
    bus.in_sad_data  = '0;
    bus.in_ack       = 1'b0;
    repeat (3) @(negedge in_clk);
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_busy", bus.out_busy, 0);
    check_eq("rst_mv_x", bus.out_mv_x, 0);
    check_eq("rst_mv_y", bus.out_mv_y, 0);
    check_eq("rst_min_sad", bus.out_min_sad, 0);
    check_eq("rst_seq_err", bus.out_seq_err, 0);
    in_rst = 1'b0;
    @(negedge in_clk);

    // Single minimum at y=5, x=9
    fill(1000);
    sads[89] = 12;
    do_start();
    check_eq("single_busy", bus.out_busy, 1);
    run_search(1'b0);
    @(negedge in_clk);
    check_eq("single_valid", bus.out_valid, 1);
    check_eq("single_mv_x", bus.out_mv_x, ex_x(9));
    check_eq("single_mv_y", bus.out_mv_y, ex_y(5));
    check_eq("single_min", bus.out_min_sad, 12);
    check_eq("single_seq_err", bus.out_seq_err, 0);
    check_eq("single_busy_done", bus.out_busy, 0);
    pulse_ack();
    check_eq("ack_valid_low", bus.out_valid, 0);
    check_eq("ack_min_held", bus.out_min_sad, 12);
    check_eq("ack_mv_x_held", bus.out_mv_x, ex_x(9));

    // Tie: candidates 3 and 200 both zero
    fill(500);
    sads[3]   = 0;
    sads[200] = 0;
    do_start();
    run_search(1'b0);
    @(negedge in_clk);
    check_eq("tie_valid", bus.out_valid, 1);
    check_eq("tie_mv_x", bus.out_mv_x, ex_x(3));
    check_eq("tie_mv_y", bus.out_mv_y, ex_y(0));
    check_eq("tie_min", bus.out_min_sad, 0);

    // Start in DONE acts as implicit ack; gaps between strobes; slow ack
    fill(1000);
    sads[89] = 12;
    do_start();
    check_eq("implicit_ack_valid", bus.out_valid, 0);
    check_eq("implicit_ack_busy", bus.out_busy, 1);
    run_search(1'b1);
    @(negedge in_clk);
    check_eq("gap_valid", bus.out_valid, 1);
    repeat (10) @(negedge in_clk);
    check_eq("hold_valid", bus.out_valid, 1);
    check_eq("hold_mv_x", bus.out_mv_x, ex_x(9));
    check_eq("hold_mv_y", bus.out_mv_y, ex_y(5));
    check_eq("hold_min", bus.out_min_sad, 12);
    pulse_ack();
    check_eq("gap_ack_valid", bus.out_valid, 0);
    check_eq("gap_ack_busy", bus.out_busy, 0);
    check_eq("gap_ack_min", bus.out_min_sad, 12);

    // Two strobes at once: PE0 (SAD 50) must win over PE1 (SAD 1)
    do_start();
    d = '1;
    d[0 +: SAD_WIDTH]         = 16'd50;
    d[SAD_WIDTH +: SAD_WIDTH] = 16'd1;
    bus.in_sad_valid = 16'h0003;
    bus.in_sad_data  = d;
    @(negedge in_clk);
    bus.in_sad_valid = '0;
    bus.in_sad_data  = '0;
    check_eq("multi_seq_err", bus.out_seq_err, 1);
    for (int i = 1; i < 256; i++) send_one(i % 16, 1000);
    @(negedge in_clk);
    check_eq("multi_valid", bus.out_valid, 1);
    check_eq("multi_mv_x", bus.out_mv_x, ex_x(0));
    check_eq("multi_mv_y", bus.out_mv_y, ex_y(0));
    check_eq("multi_min", bus.out_min_sad, 50);
    check_eq("multi_seq_sticky", bus.out_seq_err, 1);

    // Out-of-order PE, then restart after 100 SADs
    do_start();
    check_eq("start_clears_err", bus.out_seq_err, 0);
    for (int i = 0; i < 4; i++) send_one(i, 1000);
    check_eq("inorder_no_err", bus.out_seq_err, 0);
    send_one(5, 1000);
    check_eq("order_seq_err", bus.out_seq_err, 1);
    for (int i = 5; i < 100; i++) send_one(i % 16, (i == 50) ? 1 : 1000);
    d = '1;
    d[0 +: SAD_WIDTH] = 16'd0;
    bus.in_start     = 1'b1;
    bus.in_sad_valid = 16'h0001;
    bus.in_sad_data  = d;
    @(negedge in_clk);
    bus.in_start     = 1'b0;
    bus.in_sad_valid = '0;
    bus.in_sad_data  = '0;
    check_eq("restart_clears_err", bus.out_seq_err, 0);
    fill(300);
    sads[255] = 299;
    run_search(1'b0);
    @(negedge in_clk);
    check_eq("restart_valid", bus.out_valid, 1);
    check_eq("restart_mv_x", bus.out_mv_x, ex_x(15));
    check_eq("restart_mv_y", bus.out_mv_y, ex_y(15));
    check_eq("restart_min", bus.out_min_sad, 299);
    check_eq("restart_seq_err", bus.out_seq_err, 0);

    // Asynchronous reset in the middle of COLLECT
    do_start();
    for (int i = 0; i < 20; i++) send_one(i % 16, 7);
    in_rst = 1'b1;
    #1;
    check_eq("midrst_valid", bus.out_valid, 0);
    check_eq("midrst_busy", bus.out_busy, 0);
    check_eq("midrst_mv_x", bus.out_mv_x, 0);
    check_eq("midrst_mv_y", bus.out_mv_y, 0);
    check_eq("midrst_min", bus.out_min_sad, 0);
    @(negedge in_clk);
    in_rst = 1'b0;
    @(negedge in_clk);

    // Corner vectors: raw (0,0) and raw (8,15)
    fill(100);
    sads[0] = 5;
    do_start();
    run_search(1'b0);
    @(negedge in_clk);
    check_eq("corner0_mv_x", bus.out_mv_x, ex_x(0));
    check_eq("corner0_mv_y", bus.out_mv_y, ex_y(0));
    check_eq("corner0_min", bus.out_min_sad, 5);
    fill(100);
    sads[248] = 5;
    do_start();
    run_search(1'b0);
    @(negedge in_clk);
    check_eq("corner1_mv_x", bus.out_mv_x, ex_x(8));
    check_eq("corner1_mv_y", bus.out_mv_y, ex_y(15));
    check_eq("corner1_min", bus.out_min_sad, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
